twos_comp_serial_alu: RTL and testbench
=======================================

Name: twos_comp_serial_alu

Overview:
Digit-serial two's-complement unit, successor to the team's combinational negator. Computes negate, absolute value, subtract (a + ~b + 1) or pass-through on W-bit signed operands, DIGIT_W bits per clock, LSB digit first. A valid/ready handshake sits on both input and output. Intended for area-constrained datapaths where a full-width adder per op is too expensive.

Parameters:
- W, 32, operand/result width in bits; must be a multiple of DIGIT_W.
- DIGIT_W, 8, bits processed per cycle; NDIG = W/DIGIT_W cycles per op (NDIG >= 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  2  operation: 00 NEG (-a), 01 ABS (|a|), 10 SUB (a-b), 11 PASS (a).
- a  in  W  operand A, signed.
- b  in  W  operand B, signed; used only by SUB.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  W-bit two's-complement result, wrap-around.
- ovf  out  1  signed overflow for this result.

Behaviour:
- Reset values: in_ready=0 while rst_n low, then 1 from the first cycle after release. out_valid=0, result=0, ovf=0. FSM=IDLE, carry=0, digit counter=0.
- FSM IDLE -> BUSY: on in_valid && in_ready. Capture op, a, b and a_sign = a[W-1]. Load initial carry and clear the digit counter. in_ready=1 only in IDLE.
- Operand mapping, per digit: sum = x_d + y_d + carry.
  - NEG: x=~a, y=0, cin=1.
  - SUB: x=a, y=~b, cin=1.
  - PASS: x=a, y=0, cin=0.
  - ABS: behaves as NEG if a_sign=1, otherwise as PASS.
- BUSY: each cycle computes one DIGIT_W slice (digit k = bits [k*DIGIT_W +: DIGIT_W]). It writes the slice into the result shift register and registers carry-out as the next carry-in. Counter increments. After digit NDIG-1 the FSM goes to DONE.
- Latency: out_valid rises exactly NDIG cycles after the accept edge (4 at defaults).
- DONE: out_valid=1. result and ovf are held stable until out_ready. On out_valid && out_ready: go to IDLE, out_valid=0 next cycle. Back-to-back throughput is one op per NDIG+2 cycles.
- ovf rules:
  - NEG or ABS: ovf=1 iff a == 2^(W-1) (most-negative); result is then 2^(W-1) (wraps).
  - SUB: ovf=1 iff a[W-1] != b[W-1] && result[W-1] != a[W-1].
  - PASS: ovf=0.
- in_valid while BUSY/DONE: ignored (in_ready=0); the upstream source must hold the request.
- out_ready while not DONE: no effect.
- Reset mid-operation: asynchronously aborts to the reset state; a partial result is never presented.
- Captured operands are stable for the whole op; input changes after accept have no effect.

Decomposition:
- Shared package (tc_pkg): op encoding localparams OP_NEG=2'b00, OP_ABS=2'b01, OP_SUB=2'b10, OP_PASS=2'b11; FSM state encoding IDLE/BUSY/DONE.
- One sub-module, tc_digit_add: combinational DIGIT_W-bit adder slice (x, y, cin -> sum, cout), instantiated once. The top level owns the FSM, operand shift registers, carry register, result register and ovf logic.

Test Plan:
- NEG a=32'd12 -> result=32'hFFFF_FFF4, ovf=0, out_valid exactly 4 cycles after the accept edge.
- SUB a=69, b=12 -> result=57, ovf=0. SUB a=32'h7FFF_FFFF, b=32'hFFFF_FFFF (-1) -> result=32'h8000_0000, ovf=1.
- ABS a=32'hFFFF_FFF4 -> 12, ovf=0. ABS a=5 -> 5. ABS and NEG with a=32'h8000_0000 -> result=32'h8000_0000, ovf=1. PASS a=32'hDEAD_BEEF -> same value, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result/ovf stable, in_ready=0, a second in_valid is not accepted. Then release -> second op accepted and completes correctly.
- Reset mid-op: assert rst_n=0 in BUSY digit 2 -> out_valid=0 and result=0 immediately. After release, NEG 1 -> 32'hFFFF_FFFF.
- Parameter sweep W=4, DIGIT_W=1 and W=8, DIGIT_W=8 (NDIG=1): exhaustive NEG/ABS/SUB against a reference model; latency equals NDIG.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared definitions for the digit-serial two's-complement unit:
// op encoding, FSM states and the operand-mapping helper.
package tc_pkg;

  localparam logic [1:0] OP_NEG  = 2'b00;
  localparam logic [1:0] OP_ABS  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the op computes -a (NEG always, ABS only for a negative operand).
  function automatic logic negates_a(input logic [1:0] op, input logic a_sign);
    return (op == OP_NEG) || ((op == OP_ABS) && a_sign);
  endfunction

endpackage

// File: rtl/twos_comp_serial_alu_if.sv
// Request/response handshake bundle for twos_comp_serial_alu.
interface twos_comp_serial_alu_if #(
  parameter int unsigned W = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         ovf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, ovf
  );

endinterface

// File: rtl/tc_digit_add.sv
// Combinational DIGIT_W-bit adder slice with carry in/out.
module tc_digit_add #(
  parameter int unsigned DIGIT_W = 8
) (
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum_c,
  output logic               cout_c
);

  localparam int unsigned SUM_W = DIGIT_W + 1;

  logic [SUM_W-1:0] full_sum;

  assign full_sum = SUM_W'(x) + SUM_W'(y) + SUM_W'(cin);
  assign sum_c    = full_sum[DIGIT_W-1:0];
  assign cout_c   = full_sum[DIGIT_W];

endmodule

// File: rtl/twos_comp_serial_alu.sv
// Digit-serial NEG / ABS / SUB / PASS on W-bit signed operands, DIGIT_W bits
// per clock, LSB digit first, valid/ready on both request and result.
module twos_comp_serial_alu
  import tc_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned DIGIT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  twos_comp_serial_alu_if.slave  bus
);

  localparam int unsigned NDIG  = W / DIGIT_W;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [W-1:0] A_MIN = W'(1) << (W - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       opa_q, opa_d;
  logic [W-1:0]       opb_q, opb_d;
  logic [1:0]         op_q, op_d;
  logic               a_sign_q, a_sign_d;
  logic               b_sign_q, b_sign_d;
  logic               a_min_q, a_min_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [W-1:0]       result_q, result_d;
  logic               ovf_q, ovf_d;

  logic               neg_eff;
  logic [DIGIT_W-1:0] x_dig;
  logic [DIGIT_W-1:0] y_dig;
  logic [DIGIT_W-1:0] sum_dig;
  logic               cout;
  logic [W-1:0]       shifted;
  logic               last_dig;
  logic               ovf_calc;

  // Operand mapping for the current LSB digit of the captured operands.
  always_comb begin
    neg_eff = negates_a(op_q, a_sign_q);
    x_dig   = neg_eff ? ~opa_q[DIGIT_W-1:0] : opa_q[DIGIT_W-1:0];
    y_dig   = (op_q == OP_SUB) ? ~opb_q[DIGIT_W-1:0] : '0;
  end

  tc_digit_add #(
    .DIGIT_W (DIGIT_W)
  ) u_digit_add (
    .x      (x_dig),
    .y      (y_dig),
    .cin    (carry_q),
    .sum_c  (sum_dig),
    .cout_c (cout)
  );

  // Operand A's register doubles as the result shift register: each sum
  // digit enters at the top as the consumed digit leaves at the bottom.
  always_comb begin
    shifted  = (opa_q >> DIGIT_W) | (W'(sum_dig) << (W - DIGIT_W));
    last_dig = (cnt_q == CNT_W'(NDIG - 1));
    unique case (op_q)
      OP_NEG, OP_ABS: ovf_calc = a_min_q;
      OP_SUB:         ovf_calc = (a_sign_q != b_sign_q) && (shifted[W-1] != a_sign_q);
      default:        ovf_calc = 1'b0;
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    op_d        = op_q;
    a_sign_d    = a_sign_q;
    b_sign_d    = b_sign_q;
    a_min_d     = a_min_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d  = BUSY;
          op_d     = bus.op;
          opa_d    = bus.a;
          opb_d    = bus.b;
          a_sign_d = bus.a[W-1];
          b_sign_d = bus.b[W-1];
          a_min_d  = (bus.a == A_MIN);
          cnt_d    = '0;
          carry_d  = negates_a(bus.op, bus.a[W-1]) || (bus.op == OP_SUB);
        end
      end
      BUSY: begin
        opa_d   = shifted;
        opb_d   = opb_q >> DIGIT_W;
        carry_d = cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_dig) begin
          state_d     = DONE;
          cnt_d       = '0;
          carry_d     = 1'b0;
          result_d    = shifted;
          ovf_d       = ovf_calc;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_q        <= OP_NEG;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      a_min_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      op_q        <= op_d;
      a_sign_q    <= a_sign_d;
      b_sign_q    <= b_sign_d;
      a_min_q     <= a_min_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_twos_comp_serial_alu.sv
// Self-checking bench: directed vectors, random ops against a signed-integer
// model, backpressure, mid-op reset and two small-width configurations.
module tb_twos_comp_serial_alu;
  import tc_pkg::*;

  logic        clk;
  logic        rst_n;
  int          sel;
  logic        cur_valid;
  logic        cur_oready;
  logic [1:0]  cur_op;
  logic [31:0] cur_a;
  logic [31:0] cur_b;

  logic        m_in_ready;
  logic        m_out_valid;
  logic [31:0] m_res;
  logic        m_ovf;

  int n_tests;
  int n_fail;

  twos_comp_serial_alu_if #(.W(32)) if32 ();
  twos_comp_serial_alu_if #(.W(4))  if4  ();
  twos_comp_serial_alu_if #(.W(8))  if8  ();

  twos_comp_serial_alu #(.W(32), .DIGIT_W(8)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  twos_comp_serial_alu #(.W(4),  .DIGIT_W(1)) u4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  twos_comp_serial_alu #(.W(8),  .DIGIT_W(8)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8));

  assign if32.in_valid  = cur_valid && (sel == 0);
  assign if32.op        = cur_op;
  assign if32.a         = cur_a;
  assign if32.b         = cur_b;
  assign if32.out_ready = cur_oready;
  assign if4.in_valid   = cur_valid && (sel == 1);
  assign if4.op         = cur_op;
  assign if4.a          = cur_a[3:0];
  assign if4.b          = cur_b[3:0];
  assign if4.out_ready  = cur_oready;
  assign if8.in_valid   = cur_valid && (sel == 2);
  assign if8.op         = cur_op;
  assign if8.a          = cur_a[7:0];
  assign if8.b          = cur_b[7:0];
  assign if8.out_ready  = cur_oready;

  always_comb begin
    m_in_ready  = 1'b0;
    m_out_valid = 1'b0;
    m_res       = 32'd0;
    m_ovf       = 1'b0;
    case (sel)
      0: begin m_in_ready = if32.in_ready; m_out_valid = if32.out_valid; m_res = if32.result;      m_ovf = if32.ovf; end
      1: begin m_in_ready = if4.in_ready;  m_out_valid = if4.out_valid;  m_res = 32'(if4.result);  m_ovf = if4.ovf;  end
      2: begin m_in_ready = if8.in_ready;  m_out_valid = if8.out_valid;  m_res = 32'(if8.result);  m_ovf = if8.ovf;  end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Signed-integer reference: overflow means the true result is not representable in w bits.
  function automatic logic [32:0] model(input int w, input logic [1:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    longint m, sa, sb, r, rr;
    logic   ov;
    m  = longint'(1) << w;
    sa = longint'({32'd0, a}) & (m - 1);
    sb = longint'({32'd0, b}) & (m - 1);
    if (sa >= m / 2) sa -= m;
    if (sb >= m / 2) sb -= m;
    case (op)
      OP_NEG:  r = -sa;
      OP_ABS:  r = (sa < 0) ? -sa : sa;
      OP_SUB:  r = sa - sb;
      default: r = sa;
    endcase
    ov = (r >= m / 2) || (r < -(m / 2));
    rr = r % m;
    if (rr < 0) rr += m;
    return {ov, rr[31:0]};
  endfunction

  // One request/response; lat counts edges from the accept edge to out_valid.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ov, output int lat);
    int n;
    cur_op    = op;
    cur_a     = a;
    cur_b     = b;
    cur_valid = 1'b1;
    n = 0;
    while (!m_in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!m_in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk); #1;
    cur_valid = 1'b0;
    cur_a     = $urandom;
    cur_b     = $urandom;
    lat = 0;
    while (!m_out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = m_res;
    ov  = m_ovf;
    if (cur_oready) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] res;
  logic        ov;
  int          lat;
  logic [32:0] exp_m;
  logic        bp_stable;
  logic        bp_ready_seen;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    sel        = 0;
    cur_valid  = 1'b0;
    cur_oready = 1'b1;
    cur_op     = OP_NEG;
    cur_a      = '0;
    cur_b      = '0;

    vecs[0]  = '{OP_NEG,  32'd12,          32'd0,           32'hFFFF_FFF4, 1'b0};
    vecs[1]  = '{OP_SUB,  32'd69,          32'd12,          32'd57,        1'b0};
    vecs[2]  = '{OP_SUB,  32'h7FFF_FFFF,   32'hFFFF_FFFF,   32'h8000_0000, 1'b1};
    vecs[3]  = '{OP_ABS,  32'hFFFF_FFF4,   32'd0,           32'd12,        1'b0};
    vecs[4]  = '{OP_ABS,  32'd5,           32'd0,           32'd5,         1'b0};
    vecs[5]  = '{OP_ABS,  32'h8000_0000,   32'd0,           32'h8000_0000, 1'b1};
    vecs[6]  = '{OP_NEG,  32'h8000_0000,   32'd0,           32'h8000_0000, 1'b1};
    vecs[7]  = '{OP_PASS, 32'hDEAD_BEEF,   32'h1234_5678,   32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{OP_SUB,  32'h8000_0000,   32'd1,           32'h7FFF_FFFF, 1'b1};
    vecs[9]  = '{OP_NEG,  32'd0,           32'd0,           32'd0,         1'b0};
    vecs[10] = '{OP_SUB,  32'd5,           32'd5,           32'd0,         1'b0};
    vecs[11] = '{OP_SUB,  32'd0,           32'h8000_0000,   32'h8000_0000, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(m_in_ready),  32'd0);
    chk("rst_out_valid", 32'(m_out_valid), 32'd0);
    chk("rst_result",    m_res,            32'd0);
    chk("rst_ovf",       32'(m_ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(m_in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, ov, lat);
      chk($sformatf("vec%0d_res", i), res,     vecs[i].exp_res);
      chk($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
    end

    for (int i = 0; i < 150; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = 32'h8000_0000;
      if ($urandom_range(0, 9) == 0) ra = 32'h7FFF_FFFF;
      run_op(rop, ra, rb, res, ov, lat);
      exp_m = model(32, rop, ra, rb);
      chk($sformatf("rnd%0d_op%0d_res", i, rop), res,     exp_m[31:0]);
      chk($sformatf("rnd%0d_op%0d_ovf", i, rop), 32'(ov), 32'(exp_m[32]));
    end

    // Backpressure: result held, second request stalled until released.
    cur_oready = 1'b0;
    run_op(OP_NEG, 32'd100, 32'd0, res, ov, lat);
    chk("bp_res", res, 32'hFFFF_FF9C);
    chk("bp_lat", 32'(lat), 32'd4);
    cur_op        = OP_PASS;
    cur_a         = 32'd77;
    cur_b         = 32'd0;
    cur_valid     = 1'b1;
    bp_stable     = 1'b1;
    bp_ready_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (m_res !== 32'hFFFF_FF9C || m_ovf !== 1'b0 || m_out_valid !== 1'b1) bp_stable = 1'b0;
      if (m_in_ready !== 1'b0) bp_ready_seen = 1'b1;
    end
    chk("bp_hold_stable",  32'(bp_stable),     32'd1);
    chk("bp_in_ready_low", 32'(bp_ready_seen), 32'd0);
    cur_oready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 32'(m_out_valid), 32'd0);
    chk("bp_release_in_ready",  32'(m_in_ready),  32'd1);
    run_op(OP_PASS, 32'd77, 32'd0, res, ov, lat);
    chk("bp_second_res", res,     32'd77);
    chk("bp_second_ovf", 32'(ov), 32'd0);

    // Reset while the third digit is being computed.
    cur_op    = OP_NEG;
    cur_a     = 32'd12;
    cur_valid = 1'b1;
    @(posedge clk); #1;
    cur_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(m_out_valid), 32'd0);
    chk("midrst_result",    m_res,            32'd0);
    chk("midrst_in_ready",  32'(m_in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_NEG, 32'd1, 32'd0, res, ov, lat);
    chk("postrst_res", res,      32'hFFFF_FFFF);
    chk("postrst_lat", 32'(lat), 32'd4);

    // W=4, DIGIT_W=1: exhaustive NEG/ABS/SUB/PASS.
    sel = 1;
    for (int o = 0; o < 4; o++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          if (o != int'(OP_SUB) && ib > 0) continue;
          run_op(2'(o), 32'(ia), 32'(ib), res, ov, lat);
          exp_m = model(4, 2'(o), 32'(ia), 32'(ib));
          chk($sformatf("w4_op%0d_a%0d_b%0d_res", o, ia, ib), res,      exp_m[31:0]);
          chk($sformatf("w4_op%0d_a%0d_b%0d_ovf", o, ia, ib), 32'(ov),  32'(exp_m[32]));
          chk($sformatf("w4_op%0d_a%0d_b%0d_lat", o, ia, ib), 32'(lat), 32'd4);
        end
      end
    end

    // W=8, DIGIT_W=8 (single digit): exhaustive NEG/ABS, random SUB.
    sel = 2;
    for (int o = 0; o < 2; o++) begin
      for (int ia = 0; ia < 256; ia++) begin
        run_op(2'(o), 32'(ia), 32'd0, res, ov, lat);
        exp_m = model(8, 2'(o), 32'(ia), 32'd0);
        chk($sformatf("w8_op%0d_a%0d_res", o, ia), res,      exp_m[31:0]);
        chk($sformatf("w8_op%0d_a%0d_ovf", o, ia), 32'(ov),  32'(exp_m[32]));
        chk($sformatf("w8_op%0d_a%0d_lat", o, ia), 32'(lat), 32'd1);
      end
    end
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = 32'($urandom_range(0, 255));
      rb = 32'($urandom_range(0, 255));
      run_op(OP_SUB, ra, rb, res, ov, lat);
      exp_m = model(8, OP_SUB, ra, rb);
      chk($sformatf("w8_sub_a%0d_b%0d_res", ra, rb), res,      exp_m[31:0]);
      chk($sformatf("w8_sub_a%0d_b%0d_ovf", ra, rb), 32'(ov),  32'(exp_m[32]));
      chk($sformatf("w8_sub_a%0d_b%0d_lat", ra, rb), 32'(lat), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
